// File: rtl/addr_router_pkg.sv
// Shared types and defaults for addr_router: region record, slave-id width helper, reset region map.
// Region fields are held at a fixed maximum width; instances use the low ADDR_WIDTH bits.
package addr_router_pkg;

  localparam int AR_MAX_AW = 64;

  localparam logic [127:0] DEF_BASE_PACKED = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000};
  localparam logic [127:0] DEF_SIZE_PACKED = {32'h0000_1000, 32'h0000_1000, 32'h0000_1000, 32'h0000_1000};

  typedef struct packed {
    logic [AR_MAX_AW-1:0] base;
    logic [AR_MAX_AW-1:0] size;
    logic                 en;
  } region_t;

  function automatic int slave_id_w(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/region_match.sv
// Combinational hit test for one region: en && base <= addr < base + size, evaluated without wrap.
// No state, no handshake; size 0 never hits and a region may end exactly at 2^ADDR_WIDTH.
module region_match
  import addr_router_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH-1:0] size,
  input  logic                  en,
  output logic                  hit
);

  // The extra MSB is the borrow: set when addr < base.
  logic [ADDR_WIDTH:0] offset;

  assign offset = {1'b0, addr} - {1'b0, base};
  assign hit    = en && !offset[ADDR_WIDTH] && (offset < {1'b0, size});

endmodule

// File: rtl/addr_router.sv
// Address decoder to M programmable regions, lowest index wins; one registered stage (latency 1).
// req_ready = !rsp_valid || rsp_ready, outputs hold while stalled; ADDR_ROUTER_DECERR_CNT_EN adds a decode-error counter.
module addr_router
  import addr_router_pkg::*;
#(
  parameter int                      M                = 4,
  parameter int                      ADDR_WIDTH       = 32,
  parameter logic [M*ADDR_WIDTH-1:0] BASE_ADDR_PACKED = DEF_BASE_PACKED,
  parameter logic [M*ADDR_WIDTH-1:0] SIZE_PACKED      = DEF_SIZE_PACKED,
  parameter int                      DECERR_CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [ADDR_WIDTH-1:0]        req_addr,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [ADDR_WIDTH-1:0]        rsp_addr,
  output logic [slave_id_w(M)-1:0]     rsp_slave_id,
  output logic                         rsp_decerr,
  input  logic                         cfg_we,
  input  logic [slave_id_w(M)-1:0]     cfg_idx,
  input  logic [ADDR_WIDTH-1:0]        cfg_base,
  input  logic [ADDR_WIDTH-1:0]        cfg_size,
  input  logic                         cfg_en
`ifdef ADDR_ROUTER_DECERR_CNT_EN
  ,
  input  logic                         decerr_cnt_clr,
  output logic [DECERR_CNT_W-1:0]      decerr_cnt
`endif
);

  localparam int SID_W = slave_id_w(M);

  region_t regs_q [M];
  region_t regs_d [M];

  logic [M-1:0]          hit;
  logic [SID_W-1:0]      dec_id;
  logic                  dec_err;
  logic                  accept;

  logic                  rsp_valid_q, rsp_valid_d;
  logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
  logic [SID_W-1:0]      rsp_slave_id_q, rsp_slave_id_d;
  logic                  rsp_decerr_q, rsp_decerr_d;

  // Region map: independent of the request path, so a write never stalls requests.
  always_comb begin
    regs_d = regs_q;
    if (cfg_we && (32'(cfg_idx) < M)) begin
      regs_d[cfg_idx].base = AR_MAX_AW'(cfg_base);
      regs_d[cfg_idx].size = AR_MAX_AW'(cfg_size);
      regs_d[cfg_idx].en   = cfg_en;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < M; i++) begin
        regs_q[i].base <= AR_MAX_AW'(BASE_ADDR_PACKED[i*ADDR_WIDTH +: ADDR_WIDTH]);
        regs_q[i].size <= AR_MAX_AW'(SIZE_PACKED[i*ADDR_WIDTH +: ADDR_WIDTH]);
        regs_q[i].en   <= 1'b1;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  for (genvar g = 0; g < M; g++) begin : g_region
    region_match #(.ADDR_WIDTH(ADDR_WIDTH)) u_match (
      .addr (req_addr),
      .base (regs_q[g].base[ADDR_WIDTH-1:0]),
      .size (regs_q[g].size[ADDR_WIDTH-1:0]),
      .en   (regs_q[g].en),
      .hit  (hit[g])
    );
    if (ADDR_WIDTH < AR_MAX_AW) begin : g_hi
      logic unused_hi;
      assign unused_hi = |{regs_q[g].base[AR_MAX_AW-1:ADDR_WIDTH], regs_q[g].size[AR_MAX_AW-1:ADDR_WIDTH]};
    end
  end

  // Descending scan so the lowest matching index is the last assignment.
  always_comb begin
    dec_id  = '0;
    dec_err = 1'b1;
    for (int i = M - 1; i >= 0; i--) begin
      if (hit[i]) begin
        dec_id  = SID_W'(i);
        dec_err = 1'b0;
      end
    end
  end

  assign req_ready = !rsp_valid_q || rsp_ready;
  assign accept    = req_valid && req_ready;

  always_comb begin
    rsp_valid_d    = rsp_valid_q;
    rsp_addr_d     = rsp_addr_q;
    rsp_slave_id_d = rsp_slave_id_q;
    rsp_decerr_d   = rsp_decerr_q;
    if (accept) begin
      rsp_valid_d    = 1'b1;
      rsp_addr_d     = req_addr;
      rsp_slave_id_d = dec_id;
      rsp_decerr_d   = dec_err;
    end else if (rsp_ready) begin
      rsp_valid_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q    <= 1'b0;
      rsp_addr_q     <= '0;
      rsp_slave_id_q <= '0;
      rsp_decerr_q   <= 1'b0;
    end else begin
      rsp_valid_q    <= rsp_valid_d;
      rsp_addr_q     <= rsp_addr_d;
      rsp_slave_id_q <= rsp_slave_id_d;
      rsp_decerr_q   <= rsp_decerr_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_addr     = rsp_addr_q;
  assign rsp_slave_id = rsp_slave_id_q;
  assign rsp_decerr   = rsp_decerr_q;

`ifdef ADDR_ROUTER_DECERR_CNT_EN
  logic [DECERR_CNT_W-1:0] decerr_cnt_q, decerr_cnt_d;

  // Clear beats a same-cycle increment; count saturates at all-ones.
  always_comb begin
    decerr_cnt_d = decerr_cnt_q;
    if (decerr_cnt_clr) begin
      decerr_cnt_d = '0;
    end else if (rsp_valid_q && rsp_ready && rsp_decerr_q && (decerr_cnt_q != '1)) begin
      decerr_cnt_d = decerr_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      decerr_cnt_q <= '0;
    end else begin
      decerr_cnt_q <= decerr_cnt_d;
    end
  end

  assign decerr_cnt = decerr_cnt_q;
`endif

endmodule

// File: tb/tb_addr_router.sv
// Self-checking bench for addr_router: directed scenarios plus randomized traffic against a region-list model.
module tb_addr_router;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_addr;
  logic [1:0]  rsp_slave_id;
  logic        rsp_decerr;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [31:0] cfg_base = '0;
  logic [31:0] cfg_size = '0;
  logic        cfg_en = 1'b0;
`ifdef ADDR_ROUTER_DECERR_CNT_EN
  logic        decerr_cnt_clr = 1'b0;
  logic [15:0] decerr_cnt;
  int          m_cnt;
`endif

  always #5 clk = ~clk;

  addr_router dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_addr      (rsp_addr),
    .rsp_slave_id  (rsp_slave_id),
    .rsp_decerr    (rsp_decerr),
    .cfg_we        (cfg_we),
    .cfg_idx       (cfg_idx),
    .cfg_base      (cfg_base),
    .cfg_size      (cfg_size),
    .cfg_en        (cfg_en)
`ifdef ADDR_ROUTER_DECERR_CNT_EN
    ,
    .decerr_cnt_clr(decerr_cnt_clr),
    .decerr_cnt    (decerr_cnt)
`endif
  );

  int          n_checks = 0;
  int          n_pass   = 0;

  // Reference model: list of regions plus the one response slot.
  longint      m_base [4];
  longint      m_size [4];
  bit          m_en   [4];
  bit          m_valid;
  logic [31:0] m_addr;
  int          m_id;
  bit          m_err;

  function automatic void ref_decode(input logic [31:0] a, output int id, output bit err);
    longint a64 = {32'b0, a};
    err = 1'b1;
    id  = 0;
    for (int i = 0; i < 4; i++) begin
      if (err && m_en[i] && a64 >= m_base[i] && a64 < m_base[i] + m_size[i]) begin
        id  = i;
        err = 1'b0;
      end
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_base[i] = longint'(i) * 64'h1000;
      m_size[i] = 64'h1000;
      m_en[i]   = 1'b1;
    end
    m_valid = 1'b0;
    m_addr  = '0;
    m_id    = 0;
    m_err   = 1'b0;
`ifdef ADDR_ROUTER_DECERR_CNT_EN
    m_cnt   = 0;
`endif
  endtask

  // Advance the model by one clock from the currently driven inputs, then wait for the edge.
  task automatic tick();
    bit acc;
    int id;
    bit err;
    acc = req_valid && (!m_valid || rsp_ready);
`ifdef ADDR_ROUTER_DECERR_CNT_EN
    if (decerr_cnt_clr) m_cnt = 0;
    else if (m_valid && rsp_ready && m_err && m_cnt < 65535) m_cnt++;
`endif
    if (acc) begin
      ref_decode(req_addr, id, err);
      m_valid = 1'b1;
      m_addr  = req_addr;
      m_id    = id;
      m_err   = err;
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
    if (cfg_we) begin
      m_base[cfg_idx] = {32'b0, cfg_base};
      m_size[cfg_idx] = {32'b0, cfg_size};
      m_en[cfg_idx]   = cfg_en;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit v, input logic [31:0] a, input bit r);
    req_valid = v;
    req_addr  = a;
    rsp_ready = r;
  endtask

  task automatic set_cfg(input bit we, input logic [1:0] idx, input logic [31:0] b, input logic [31:0] s, input bit en);
    cfg_we   = we;
    cfg_idx  = idx;
    cfg_base = b;
    cfg_size = s;
    cfg_en   = en;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({rsp_valid, rsp_addr, rsp_slave_id, rsp_decerr} !== 36'b0) $display("FAIL reset_outputs: got v=%0b addr=%h id=%0d err=%0b, want all zero", rsp_valid, rsp_addr, rsp_slave_id, rsp_decerr);
    else n_pass++;
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %0b want 1", req_ready);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    set_req(1, 32'h2004, 1);
    tick();
    n_checks++;
    if ({rsp_valid, rsp_slave_id, rsp_decerr, rsp_addr} !== {1'b1, 2'd2, 1'b0, 32'h2004}) $display("FAIL basic_hit: got v=%0b id=%0d err=%0b addr=%h, want v=1 id=2 err=0 addr=00002004", rsp_valid, rsp_slave_id, rsp_decerr, rsp_addr);
    else n_pass++;
    set_req(1, 32'h4000, 1);
    tick();
    n_checks++;
    if ({rsp_valid, rsp_slave_id, rsp_decerr, rsp_addr} !== {1'b1, 2'd0, 1'b1, 32'h4000}) $display("FAIL basic_decerr: got v=%0b id=%0d err=%0b addr=%h, want v=1 id=0 err=1 addr=00004000", rsp_valid, rsp_slave_id, rsp_decerr, rsp_addr);
    else n_pass++;
    set_req(0, 32'h0, 1);
    tick();
    n_checks++;
    if (rsp_valid !== 1'b0) $display("FAIL basic_drain: got v=%0b want 0", rsp_valid);
    else n_pass++;
`ifdef ADDR_ROUTER_DECERR_CNT_EN
    n_checks++;
    if (decerr_cnt !== 16'd1) $display("FAIL cnt_one: got %0d want 1", decerr_cnt);
    else n_pass++;
    set_req(1, 32'h5000, 1);
    tick();
    set_req(0, 32'h0, 1);
    decerr_cnt_clr = 1'b1;
    tick();
    decerr_cnt_clr = 1'b0;
    n_checks++;
    if (decerr_cnt !== 16'd0) $display("FAIL cnt_clr_wins: got %0d want 0", decerr_cnt);
    else n_pass++;
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [4];
    addrs[0] = 32'h0000_0004;
    addrs[1] = 32'h0000_1FFC;
    addrs[2] = 32'h0000_2800;
    addrs[3] = 32'h0000_3FFF;
    for (int i = 0; i < 4; i++) begin
      set_req(1, addrs[i], 1);
      #1;
      n_checks++;
      if (req_ready !== 1'b1) $display("FAIL b2b_ready[%0d]: got %0b want 1", i, req_ready);
      else n_pass++;
      tick();
      n_checks++;
      if ({rsp_valid, rsp_slave_id, rsp_decerr, rsp_addr} !== {1'b1, 2'(i), 1'b0, addrs[i]}) $display("FAIL b2b_rsp[%0d]: got v=%0b id=%0d err=%0b addr=%h, want v=1 id=%0d err=0 addr=%h", i, rsp_valid, rsp_slave_id, rsp_decerr, rsp_addr, i, addrs[i]);
      else n_pass++;
    end
    set_req(0, 32'h0, 1);
    tick();
  endtask

  task automatic test_backpressure();
    set_req(1, 32'h1000, 0);
    tick();
    set_req(1, 32'h3000, 0);
    #1;
    n_checks++;
    if (req_ready !== 1'b0) $display("FAIL stall_ready: got %0b want 0", req_ready);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({rsp_valid, rsp_slave_id, rsp_decerr, rsp_addr} !== {1'b1, 2'd1, 1'b0, 32'h1000}) $display("FAIL stall_hold[%0d]: got v=%0b id=%0d err=%0b addr=%h, want v=1 id=1 err=0 addr=00001000", i, rsp_valid, rsp_slave_id, rsp_decerr, rsp_addr);
      else n_pass++;
    end
    rsp_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL release_ready: got %0b want 1", req_ready);
    else n_pass++;
    tick();
    n_checks++;
    if ({rsp_valid, rsp_slave_id, rsp_addr} !== {1'b1, 2'd3, 32'h3000}) $display("FAIL release_next: got v=%0b id=%0d addr=%h, want v=1 id=3 addr=00003000", rsp_valid, rsp_slave_id, rsp_addr);
    else n_pass++;
    set_req(0, 32'h0, 1);
    tick();
    n_checks++;
    if (rsp_valid !== 1'b0) $display("FAIL release_drop: got v=%0b want 0", rsp_valid);
    else n_pass++;
  endtask

  task automatic test_cfg_write();
    set_cfg(1, 2'd3, 32'h8000, 32'h100, 1);
    set_req(1, 32'h3000, 1);
    tick();
    set_cfg(0, 2'd0, 32'h0, 32'h0, 0);
    n_checks++;
    if ({rsp_slave_id, rsp_decerr} !== {2'd3, 1'b0}) $display("FAIL cfg_prewrite: got id=%0d err=%0b, want id=3 err=0", rsp_slave_id, rsp_decerr);
    else n_pass++;
    set_req(1, 32'h3000, 1);
    tick();
    n_checks++;
    if ({rsp_slave_id, rsp_decerr} !== {2'd0, 1'b1}) $display("FAIL cfg_old_gone: got id=%0d err=%0b, want id=0 err=1", rsp_slave_id, rsp_decerr);
    else n_pass++;
    set_req(1, 32'h80FF, 1);
    tick();
    n_checks++;
    if ({rsp_slave_id, rsp_decerr} !== {2'd3, 1'b0}) $display("FAIL cfg_last_byte: got id=%0d err=%0b, want id=3 err=0", rsp_slave_id, rsp_decerr);
    else n_pass++;
    set_req(1, 32'h8100, 1);
    tick();
    n_checks++;
    if ({rsp_slave_id, rsp_decerr} !== {2'd0, 1'b1}) $display("FAIL cfg_past_end: got id=%0d err=%0b, want id=0 err=1", rsp_slave_id, rsp_decerr);
    else n_pass++;
    set_req(0, 32'h0, 1);
    tick();
  endtask

  task automatic test_boundaries();
    set_cfg(1, 2'd1, 32'h0, 32'h4000, 1);
    tick();
    set_cfg(1, 2'd3, 32'hFFFF_F000, 32'h1000, 1);
    set_req(1, 32'h2000, 1);
    tick();
    n_checks++;
    if ({rsp_slave_id, rsp_decerr} !== {2'd1, 1'b0}) $display("FAIL overlap_low_wins: got id=%0d err=%0b, want id=1 err=0", rsp_slave_id, rsp_decerr);
    else n_pass++;
    set_cfg(1, 2'd2, 32'h5000, 32'h0, 1);
    set_req(1, 32'hFFFF_FFFF, 1);
    tick();
    n_checks++;
    if ({rsp_slave_id, rsp_decerr} !== {2'd3, 1'b0}) $display("FAIL top_of_space: got id=%0d err=%0b, want id=3 err=0", rsp_slave_id, rsp_decerr);
    else n_pass++;
    set_cfg(0, 2'd0, 32'h0, 32'h0, 0);
    set_req(1, 32'h5000, 1);
    tick();
    n_checks++;
    if ({rsp_slave_id, rsp_decerr} !== {2'd0, 1'b1}) $display("FAIL size_zero: got id=%0d err=%0b, want id=0 err=1", rsp_slave_id, rsp_decerr);
    else n_pass++;
    set_req(1, 32'h0FFF, 1);
    tick();
    n_checks++;
    if ({rsp_slave_id, rsp_decerr} !== {2'd0, 1'b0}) $display("FAIL region0_first: got id=%0d err=%0b, want id=0 err=0", rsp_slave_id, rsp_decerr);
    else n_pass++;
    set_cfg(1, 2'd0, 32'h0, 32'h1000, 0);
    set_req(0, 32'h0, 1);
    tick();
    set_cfg(0, 2'd0, 32'h0, 32'h0, 0);
    set_req(1, 32'h0, 1);
    tick();
    n_checks++;
    if ({rsp_slave_id, rsp_decerr} !== {2'd1, 1'b0}) $display("FAIL disabled_region: got id=%0d err=%0b, want id=1 err=0", rsp_slave_id, rsp_decerr);
    else n_pass++;
    set_req(0, 32'h0, 1);
    tick();
  endtask

  task automatic test_random();
    int i;
    for (int c = 0; c < 400; c++) begin
      i = $urandom_range(0, 3);
      req_valid = ($urandom_range(0, 9) < 7);
      rsp_ready = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 3) == 0) req_addr = $urandom;
      else req_addr = m_base[i][31:0] + 32'($urandom_range(0, 32'h1100)) - 32'h80;
      if ($urandom_range(0, 19) == 0) set_cfg(1, 2'($urandom_range(0, 3)), 32'($urandom_range(0, 7)) << 12, 32'($urandom_range(0, 4)) << 11, ($urandom_range(0, 3) != 0));
      else cfg_we = 1'b0;
`ifdef ADDR_ROUTER_DECERR_CNT_EN
      decerr_cnt_clr = ($urandom_range(0, 49) == 0);
`endif
      #1;
      n_checks++;
      if (req_ready !== (!m_valid || rsp_ready)) $display("FAIL rand_ready[%0d]: got %0b want %0b", c, req_ready, (!m_valid || rsp_ready));
      else n_pass++;
      tick();
      n_checks++;
      if ({rsp_valid, rsp_slave_id, rsp_decerr, rsp_addr} !== {m_valid, 2'(m_id), m_err, m_addr}) $display("FAIL rand_rsp[%0d]: got v=%0b id=%0d err=%0b addr=%h, want v=%0b id=%0d err=%0b addr=%h", c, rsp_valid, rsp_slave_id, rsp_decerr, rsp_addr, m_valid, m_id, m_err, m_addr);
      else n_pass++;
`ifdef ADDR_ROUTER_DECERR_CNT_EN
      n_checks++;
      if (decerr_cnt !== 16'(m_cnt)) $display("FAIL rand_cnt[%0d]: got %0d want %0d", c, decerr_cnt, m_cnt);
      else n_pass++;
      decerr_cnt_clr = 1'b0;
`endif
    end
    cfg_we = 1'b0;
  endtask

  task automatic test_reset_mid();
    set_req(1, 32'h1000, 0);
    tick();
    set_req(0, 32'h0, 0);
    rst = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if ({rsp_valid, rsp_addr, rsp_slave_id} !== 35'b0) $display("FAIL midreset_clear: got v=%0b addr=%h id=%0d, want all zero", rsp_valid, rsp_addr, rsp_slave_id);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    tick();
    n_checks++;
    if (rsp_valid !== 1'b0) $display("FAIL midreset_no_replay: got v=%0b want 0", rsp_valid);
    else n_pass++;
    set_req(1, 32'h3004, 1);
    tick();
    n_checks++;
    if ({rsp_slave_id, rsp_decerr} !== {2'd3, 1'b0}) $display("FAIL midreset_region3: got id=%0d err=%0b, want id=3 err=0", rsp_slave_id, rsp_decerr);
    else n_pass++;
    set_req(1, 32'h0000_0010, 1);
    tick();
    n_checks++;
    if ({rsp_slave_id, rsp_decerr} !== {2'd0, 1'b0}) $display("FAIL midreset_region0: got id=%0d err=%0b, want id=0 err=0", rsp_slave_id, rsp_decerr);
    else n_pass++;
    set_req(1, 32'hFFFF_FFFF, 1);
    tick();
    n_checks++;
    if ({rsp_slave_id, rsp_decerr} !== {2'd0, 1'b1}) $display("FAIL midreset_top: got id=%0d err=%0b, want id=0 err=1", rsp_slave_id, rsp_decerr);
    else n_pass++;
    set_req(0, 32'h0, 1);
    tick();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_cfg_write();
    test_boundaries();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
